// File: rtl/clock_meas_pkg.sv
// Shared state encoding and default sizing for the clock period meter.
package clock_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/edge_detect.sv
// Registers the (already synchronous) measured signal and flags its rising and
// falling edges one cycle after they are sampled.
module edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic sig_q;
  logic sig_prev;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sig_q    <= 1'b0;
      sig_prev <= 1'b0;
    end else begin
      sig_q    <= sig_in;
      sig_prev <= sig_q;
    end
  end

  assign rise = sig_q & ~sig_prev;
  assign fall = ~sig_q & sig_prev;

endmodule

// File: rtl/clock_period_meter.sv
// Measures high time, low time and period of a slow signal in clk_in cycles,
// one result per completed period, and flags a signal with no edges.
module clock_period_meter
  import clock_meas_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic [7:0]       meas_count,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic rise;
  logic fall;
  logic any_edge;
  logic timed_out;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic [CNT_W-1:0] hi_hold_reg, hi_hold_next;
  logic [CNT_W-1:0] high_time_reg, high_time_next;
  logic [CNT_W-1:0] low_time_reg, low_time_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             meas_valid_reg, meas_valid_next;
  logic [7:0]       meas_count_reg, meas_count_next;
  logic             stuck_reg, stuck_next;

  logic [CNT_W:0]   sum_full;
  logic [CNT_W-1:0] sum_sat;

  edge_detect u_edge_detect (
    .clk_in (clk_in),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  assign any_edge  = rise | fall;
  // An edge arriving on the timeout cycle takes priority over the timeout.
  assign timed_out = (run_cnt_reg == TIMEOUT_CNT) && !any_edge;

  // Period = held high time + current low run, saturated on carry-out.
  assign sum_full = {1'b0, hi_hold_reg} + {1'b0, run_cnt_reg};
  generate
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_sat
      assign sum_sat[gi] = sum_full[gi] | sum_full[CNT_W];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    run_cnt_next    = run_cnt_reg;
    hi_hold_next    = hi_hold_reg;
    high_time_next  = high_time_reg;
    low_time_next   = low_time_reg;
    period_next     = period_reg;
    meas_valid_next = 1'b0;
    meas_count_next = meas_count_reg;
    stuck_next      = stuck_reg;

    if (!en) begin
      state_next   = IDLE;
      run_cnt_next = '0;
      stuck_next   = 1'b0;
    end else if (state_reg == IDLE) begin
      state_next   = SYNC;
      run_cnt_next = '0;
    end else begin
      if (any_edge) begin
        run_cnt_next = CNT_ONE;
        stuck_next   = 1'b0;
      end else if (run_cnt_reg != TIMEOUT_CNT) begin
        run_cnt_next = run_cnt_reg + CNT_ONE;
      end

      if (timed_out) begin
        stuck_next   = 1'b1;
        state_next   = SYNC;
        hi_hold_next = '0;
      end else begin
        unique case (state_reg)
          SYNC: begin
            if (rise) state_next = HIGH;
          end
          HIGH: begin
            if (fall) begin
              state_next   = LOW;
              hi_hold_next = run_cnt_reg;
            end
          end
          LOW: begin
            if (rise) begin
              state_next      = HIGH;
              high_time_next  = hi_hold_reg;
              low_time_next   = run_cnt_reg;
              period_next     = sum_sat;
              meas_valid_next = 1'b1;
              meas_count_next = meas_count_reg + 8'd1;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg      <= IDLE;
      run_cnt_reg    <= '0;
      hi_hold_reg    <= '0;
      high_time_reg  <= '0;
      low_time_reg   <= '0;
      period_reg     <= '0;
      meas_valid_reg <= 1'b0;
      meas_count_reg <= '0;
      stuck_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      run_cnt_reg    <= run_cnt_next;
      hi_hold_reg    <= hi_hold_next;
      high_time_reg  <= high_time_next;
      low_time_reg   <= low_time_next;
      period_reg     <= period_next;
      meas_valid_reg <= meas_valid_next;
      meas_count_reg <= meas_count_next;
      stuck_reg      <= stuck_next;
    end
  end

  assign high_time  = high_time_reg;
  assign low_time   = low_time_reg;
  assign period     = period_reg;
  assign meas_valid = meas_valid_reg;
  assign meas_count = meas_count_reg;
  assign stuck      = stuck_reg;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: drives high/low phase patterns and
// checks every measurement, the stuck flag, enable and reset behaviour.
module tb_clock_period_meter;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       en;
  logic       sig_in;
  logic [7:0] high_time;
  logic [7:0] low_time;
  logic [7:0] period;
  logic       meas_valid;
  logic [7:0] meas_count;
  logic       stuck;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int pulses;
  int consec;
  int last_mv_cyc;
  int last_gap;
  logic prev_mv = 1'b0;
  logic [7:0] exp_mc = 8'd0;
  int cap_h[$];
  int cap_l[$];
  int cap_p[$];

  clock_period_meter #(.CNT_W(8), .TIMEOUT(255)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .en         (en),
    .sig_in     (sig_in),
    .high_time  (high_time),
    .low_time   (low_time),
    .period     (period),
    .meas_valid (meas_valid),
    .meas_count (meas_count),
    .stuck      (stuck)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (meas_valid === 1'b1) begin
      pulses++;
      if (prev_mv) consec++;
      if (last_mv_cyc >= 0) last_gap = cyc - last_mv_cyc;
      last_mv_cyc = cyc;
      cap_h.push_back(int'(high_time));
      cap_l.push_back(int'(low_time));
      cap_p.push_back(int'(period));
      exp_mc = exp_mc + 8'd1;
      chk("meas_count_step", meas_count, exp_mc);
    end
    prev_mv = (meas_valid === 1'b1);
  endtask

  task automatic drive(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) tick();
  endtask

  task automatic periods(input int h, input int l, input int k);
    for (int i = 0; i < k; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic clear();
    pulses      = 0;
    consec      = 0;
    last_mv_cyc = -1;
    last_gap    = 0;
    cap_h.delete();
    cap_l.delete();
    cap_p.delete();
  endtask

  // Leave measurement via IDLE and come back into SYNC with the signal low.
  task automatic resync();
    en = 1'b0;
    drive(1'b0, 3);
    en = 1'b1;
    drive(1'b0, 3);
    clear();
  endtask

  task automatic chk_cap(input string tag, input int idx, input int h, input int l, input int p);
    if (cap_h.size() > idx) begin
      chk({tag, "_high"}, cap_h[idx], h);
      chk({tag, "_low"}, cap_l[idx], l);
      chk({tag, "_period"}, cap_p[idx], p);
    end else begin
      chk({tag, "_present"}, cap_h.size(), idx + 1);
    end
  endtask

  initial begin
    int bad;
    rst = 1'b1;
    en = 1'b0;
    sig_in = 1'b0;
    clear();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_high_time", high_time, 0);
    chk("rst_low_time", low_time, 0);
    chk("rst_period", period, 0);
    chk("rst_meas_valid", meas_valid, 0);
    chk("rst_meas_count", meas_count, 0);
    chk("rst_stuck", stuck, 0);

    // Toggle every cycle: period 2, a result every 2 cycles
    resync();
    periods(1, 1, 10);
    drive(1'b1, 2);
    chk("tog_pulses", pulses, 10);
    chk("tog_gap", last_gap, 2);
    chk_cap("tog_first", 0, 1, 1, 2);
    chk_cap("tog_last", 9, 1, 1, 2);

    // 14 high / 14 low
    resync();
    periods(14, 14, 3);
    drive(1'b1, 2);
    chk("p28_pulses", pulses, 3);
    chk("p28_gap", last_gap, 28);
    chk("p28_consec", consec, 0);
    chk_cap("p28", 2, 14, 14, 28);

    // 3/2 then 1/4
    resync();
    periods(3, 2, 1);
    periods(1, 4, 1);
    drive(1'b1, 2);
    chk("mix_pulses", pulses, 2);
    chk_cap("mix_a", 0, 3, 2, 5);
    chk_cap("mix_b", 1, 1, 4, 5);

    // Held low: stuck after 256 low-sampling cycles, cleared by the next edge
    resync();
    periods(2, 2, 1);
    drive(1'b0, 254);
    chk("stuck_before", stuck, 0);
    drive(1'b0, 1);
    chk("stuck_set", stuck, 1);
    drive(1'b0, 43);
    chk("stuck_hold", stuck, 1);
    chk("stuck_no_meas", pulses, 0);
    drive(1'b1, 2);
    chk("stuck_clear", stuck, 0);
    drive(1'b1, 1);
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 3);
    drive(1'b1, 2);
    chk("resume_pulses", pulses, 2);
    chk_cap("resume", 1, 3, 3, 6);
    chk("resume_stuck", stuck, 0);

    // Reset in the middle of a high phase
    resync();
    periods(5, 5, 1);
    drive(1'b1, 3);
    chk("pre_rst_period", period, 10);
    rst = 1'b1;
    sig_in = 1'b0;
    tick();
    rst = 1'b0;
    exp_mc = 8'd0;
    chk("mrst_high_time", high_time, 0);
    chk("mrst_low_time", low_time, 0);
    chk("mrst_period", period, 0);
    chk("mrst_meas_valid", meas_valid, 0);
    chk("mrst_meas_count", meas_count, 0);
    clear();
    drive(1'b0, 4);
    periods(6, 3, 1);
    drive(1'b1, 1);
    chk("mrst_no_early", pulses, 0);
    drive(1'b1, 1);
    chk("mrst_pulses", pulses, 1);
    chk_cap("mrst", 0, 6, 3, 9);
    chk("mrst_count", meas_count, 1);

    // Enable dropped mid-low for 10 cycles
    resync();
    periods(4, 4, 1);
    drive(1'b1, 4);
    drive(1'b0, 3);
    clear();
    en = 1'b0;
    drive(1'b0, 5);
    drive(1'b1, 5);
    chk("en0_pulses", pulses, 0);
    chk("en0_high", high_time, 4);
    chk("en0_low", low_time, 4);
    chk("en0_period", period, 8);
    chk("en0_count", meas_count, 2);
    chk("en0_stuck", stuck, 0);
    en = 1'b1;
    drive(1'b1, 2);
    drive(1'b0, 3);
    periods(2, 5, 2);
    drive(1'b1, 2);
    chk("en1_pulses", pulses, 2);
    chk_cap("en1", 0, 2, 5, 7);
    chk_cap("en1b", 1, 2, 5, 7);

    // 256 periods of 2/2: meas_count wraps, checked at every pulse
    resync();
    periods(2, 2, 256);
    drive(1'b1, 2);
    chk("wrap_pulses", pulses, 256);
    chk("wrap_gap", last_gap, 4);
    bad = 0;
    foreach (cap_p[i]) if (cap_p[i] != 4) bad++;
    chk("wrap_period_all4", bad, 0);

    // 200/100 saturates the period
    resync();
    periods(200, 100, 1);
    drive(1'b1, 2);
    chk("sat_pulses", pulses, 1);
    chk_cap("sat", 0, 200, 100, 255);
    chk("sat_stuck", stuck, 0);

    // Edge arriving on the timeout cycle wins over the timeout
    resync();
    periods(3, 255, 1);
    drive(1'b1, 2);
    chk("edge_wins_pulses", pulses, 1);
    chk_cap("edge_wins", 0, 3, 255, 255);
    chk("edge_wins_stuck", stuck, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
